bcd_serial_adder: RTL and testbench

//  Multi-digit packed-BCD adder built around one single-digit BCD add stage, iterated over digits.

---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit_add.sv | 25 ++
 rtl/bcd_serial_adder.sv | 131 +++++++++++++
 tb/tb_bcd_serial_adder.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and constants for the digit-serial BCD adder.
package bcd_pkg;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_ADJ = 4'd6;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_DONE
    } state_e;

    function automatic logic is_bcd(input bcd_digit_t d);
        return (d <= BCD_MAX);
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD add with decimal-adjust; non-BCD inputs still follow
// the same rule, keeping only the low nibble of the adjusted sum.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_digit_t a_i,
    input  bcd_digit_t b_i,
    input  logic       cin_i,
    output bcd_digit_t sum_c,
    output logic       cout_c
);

    logic [4:0] t;

    always_comb begin
        t      = 5'(a_i) + 5'(b_i) + 5'(cin_i);
        sum_c  = t[3:0];
        cout_c = 1'b0;
        if (t > 5'(BCD_MAX)) begin
            sum_c  = 4'(t + 5'(BCD_ADJ));
            cout_c = 1'b1;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder: captures operands, adds one digit per clock (LSD first)
// through a single digit stage, then presents sum/carry/err until the consumer takes them.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] a_bcd,
    input  logic [4*DIGITS-1:0] b_bcd,
    input  logic                cin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] sum_bcd,
    output logic                cout,
    output logic                err
);

    localparam int unsigned    IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    state_e                       state_q, state_d;
    logic [IDX_W-1:0]             idx_q, idx_d;
    logic                         carry_q, carry_d;
    logic [DIGITS-1:0][3:0]       a_q, a_d, b_q, b_d;
    logic [DIGITS-1:0][3:0]       sum_q, sum_d;
    logic                         cout_q, cout_d;
    logic                         err_q, err_d;
    logic                         in_ready_q, out_valid_q;

    logic [DIGITS-1:0][3:0]       a_in, b_in;
    logic                         in_bad_c;
    bcd_digit_t                   dig_sum_c;
    logic                         dig_cout_c;

    assign a_in = a_bcd;
    assign b_in = b_bcd;

    // Any non-BCD digit among the incoming operands flags the whole transaction.
    always_comb begin
        in_bad_c = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (!is_bcd(a_in[i]) || !is_bcd(b_in[i])) begin
                in_bad_c = 1'b1;
            end
        end
    end

    bcd_digit_add u_digit (
        .a_i    (a_q[idx_q]),
        .b_i    (b_q[idx_q]),
        .cin_i  (carry_q),
        .sum_c  (dig_sum_c),
        .cout_c (dig_cout_c)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d = S_ADD;
                    a_d     = a_in;
                    b_d     = b_in;
                    carry_d = cin;
                    idx_d   = '0;
                    err_d   = in_bad_c;
                end
            end
            S_ADD: begin
                sum_d[idx_q] = dig_sum_c;
                carry_d      = dig_cout_c;
                idx_d        = idx_q + IDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                    cout_d  = dig_cout_c;
                    idx_d   = '0;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            err_q       <= err_d;
            in_ready_q  <= (state_d == S_IDLE);
            out_valid_q <= (state_d == S_DONE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum_bcd   = sum_q;
    assign cout      = cout_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Randomized self-checking bench for bcd_serial_adder against a decimal-arithmetic model.
`timescale 1ns/1ps
module tb_bcd_serial_adder;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 4 * DIGITS;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         in_valid  = 1'b0;
    logic         cin       = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a_bcd     = '0;
    logic [W-1:0] b_bcd     = '0;
    logic         in_ready, out_valid, cout, err;
    logic [W-1:0] sum_bcd;

    logic [W-1:0] exp_sum  = '0;
    logic         exp_cout = 1'b0;
    logic         exp_err  = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_serial_adder #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_bcd     (a_bcd),
        .b_bcd     (b_bcd),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum_bcd   (sum_bcd),
        .cout      (cout),
        .err       (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference: plain decimal addition for clean operands, digit-rule fallback otherwise.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                                  output logic [W-1:0] s, output logic co, output logic e);
        int av = 0;
        int bv = 0;
        int r;
        int t;
        int carry;
        e  = 1'b0;
        s  = '0;
        co = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++)
            if (a[4*i +: 4] > 4'd9 || b[4*i +: 4] > 4'd9) e = 1'b1;
        if (!e) begin
            for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
                av = av * 10 + int'(a[4*i +: 4]);
                bv = bv * 10 + int'(b[4*i +: 4]);
            end
            r  = av + bv + int'(c);
            co = (r >= 10 ** DIGITS);
            for (int i = 0; i < int'(DIGITS); i++) begin
                s[4*i +: 4] = 4'(r % 10);
                r = r / 10;
            end
        end else begin
            carry = int'(c);
            for (int i = 0; i < int'(DIGITS); i++) begin
                t = int'(a[4*i +: 4]) + int'(b[4*i +: 4]) + carry;
                if (t > 9) begin
                    t     = t + 6;
                    carry = 1;
                end else begin
                    carry = 0;
                end
                s[4*i +: 4] = 4'(t % 16);
            end
            co = 1'(carry);
        end
    endfunction

    task automatic pin(input string name, input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                       input logic [W-1:0] xs, input logic xc, input logic xe);
        logic [W-1:0] ms;
        logic         mc, me;
        model(a, b, c, ms, mc, me);
        check({name, "_sum"}, 32'(ms), 32'(xs));
        check({name, "_cout"}, 32'(mc), 32'(xc));
        check({name, "_err"}, 32'(me), 32'(xe));
    endtask

    // Whenever a result is presented, it must match the model for the accepted operands.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            check("mon_sum", 32'(sum_bcd), 32'(exp_sum));
            check("mon_cout", 32'(cout), 32'(exp_cout));
            check("mon_err", 32'(err), 32'(exp_err));
            check("mon_in_ready_busy", 32'(in_ready), 32'd0);
        end
    end

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input int hold, input bit early);
        logic [W-1:0] ms;
        logic         mc, me;
        int           k;
        model(a, b, c, ms, mc, me);
        @(negedge clk);
        in_valid  = 1'b1;
        a_bcd     = a;
        b_bcd     = b;
        cin       = c;
        out_ready = early;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        exp_sum  = ms;
        exp_cout = mc;
        exp_err  = me;
        @(negedge clk);
        in_valid = 1'b0;
        a_bcd    = W'($urandom);
        b_bcd    = W'($urandom);
        cin      = 1'($urandom);
        check("busy_in_ready", 32'(in_ready), 32'd0);
        k = 0;
        while (!out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("latency", 32'(k), 32'(DIGITS));
        if (hold > 0) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            repeat (hold) @(negedge clk);
            in_valid  = 1'b0;
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("post_out_valid", 32'(out_valid), 32'd0);
        check("post_in_ready", 32'(in_ready), 32'd1);
        check("post_sum_held", 32'(sum_bcd), 32'(ms));
    endtask

    task automatic rand_operand(output logic [W-1:0] v);
        v = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if ($urandom_range(0, 11) == 0) v[4*i +: 4] = 4'($urandom_range(0, 15));
            else                            v[4*i +: 4] = 4'($urandom_range(0, 9));
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        int           hold, t0, t1, n_acc, k;
        bit           early;

        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum_bcd), 32'd0);
        check("rst_cout_err", {30'd0, cout, err}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        pin("pin1", 16'h1234, 16'h5678, 1'b0, 16'h6912, 1'b0, 1'b0);
        pin("pin2", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        pin("pin3", 16'h4999, 16'h5000, 1'b1, 16'h0000, 1'b1, 1'b0);
        pin("pin3b", 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0);
        pin("pin4", 16'h000A, 16'h0000, 1'b0, 16'h0010, 1'b0, 1'b1);

        run_op(16'h1234, 16'h5678, 1'b0, 0, 1'b0);
        run_op(16'h9999, 16'h0001, 1'b0, 0, 1'b1);
        run_op(16'h4999, 16'h5000, 1'b1, 0, 1'b0);
        run_op(16'h0000, 16'h0000, 1'b1, 0, 1'b0);
        run_op(16'h000A, 16'h0000, 1'b0, 0, 1'b0);
        run_op(16'h0042, 16'h0057, 1'b0, 0, 1'b0);
        run_op(16'h2718, 16'h3141, 1'b1, 10, 1'b0);

        // Reset in the middle of ADD aborts the transaction.
        @(negedge clk);
        in_valid = 1'b1;
        a_bcd    = 16'h1234;
        b_bcd    = 16'h5678;
        cin      = 1'b0;
        k = 0;
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum_bcd), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_idle", 32'(in_ready), 32'd1);
        run_op(16'h0815, 16'h4711, 1'b0, 0, 1'b0);

        // Back-to-back with handshakes always ready: one accept every DIGITS+2 cycles.
        model(16'h0123, 16'h0456, 1'b0, exp_sum, exp_cout, exp_err);
        @(negedge clk);
        a_bcd     = 16'h0123;
        b_bcd     = 16'h0456;
        cin       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n_acc = 0;
        t0 = 0;
        t1 = 0;
        k  = 0;
        while (n_acc < 2 && k < 40) begin
            if (in_ready) begin
                if (n_acc == 0) t0 = cyc;
                else            t1 = cyc;
                n_acc++;
            end
            @(negedge clk);
            k++;
        end
        in_valid = 1'b0;
        repeat (DIGITS + 3) @(negedge clk);
        out_ready = 1'b0;
        check("throughput", 32'(t1 - t0), 32'(DIGITS + 2));

        for (int n = 0; n < 40; n++) begin
            rand_operand(ra);
            rand_operand(rb);
            hold  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            early = (hold == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            run_op(ra, rb, 1'($urandom), hold, early);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1);
    end

endmodule
